boot_sequencer: RTL and testbench

Load-and-release controller for the Mini-MIPS core. It accepts a word stream over a valid/ready handshake: a header word first, then the instruction words, then the data words. It writes the instruction words into instruction memory and the data words into data memory, each starting at address 0, while the core is held in reset. After the last word it releases the core and asserts `done`. It sits between the host/UART front end and the processor's memory-load ports.

---
 rtl/boot_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_boot_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_sequencer.sv
// boot_sequencer
// Loads a host word stream into the Mini-MIPS instruction and data memories
// while holding the core in reset, then releases the core.
// The stream is one header word {icnt[31:16], dcnt[15:0]}, then icnt
// instruction words, then dcnt data words. Each section is written starting
// at address 0.
//
// Ports
//   i_clk        system clock, all state on the rising edge
//   i_rst        synchronous active-high reset
//   i_in_valid   host word valid
//   o_in_ready   block accepts a word (IDLE, LOAD_I, LOAD_D)
//   i_in_data    host word
//   i_reload     single-cycle request to reload, honoured only in RUN
//   o_inst_we    instruction-memory write strobe (registered)
//   o_data_we    data-memory write strobe (registered)
//   o_mem_addr   shared write address (registered)
//   o_mem_wdata  shared write data (registered)
//   o_cpu_rst    core reset hold, low only in RUN
//   o_busy       high in LOAD_I, LOAD_D, RELEASE
//   o_done       high in RUN
//   o_err        high in ERROR, held until i_rst
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | waiting for the header word
// S_LOAD_I  | accepting instruction words into imem
// S_LOAD_D  | accepting data words into dmem
// S_RELEASE | one-cycle gap while the last write lands
// S_RUN     | core released; waits for i_reload
// S_ERROR   | header count out of range; terminal until i_rst
module boot_sequencer #(
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 2048
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_data,
  input  logic              i_reload,
  output logic              o_inst_we,
  output logic              o_data_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_cpu_rst,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  // One extra bit so that a count of exactly MEM_DEPTH is representable.
  localparam int          CW      = ADDR_W + 1;
  localparam logic [15:0] MAX_CNT = 16'(MEM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_I,
    S_LOAD_D,
    S_RELEASE,
    S_RUN,
    S_ERROR
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]     r_idx;
  logic [CW-1:0]     r_icnt;
  logic [CW-1:0]     r_dcnt;
  logic              r_inst_we;
  logic              r_data_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic        w_xfer;
  logic [15:0] w_hdr_icnt;
  logic [15:0] w_hdr_dcnt;
  logic        w_hdr_bad;
  logic        w_last_i;
  logic        w_last_d;

  assign w_xfer     = i_in_valid & o_in_ready;
  assign w_hdr_icnt = i_in_data[31:16];
  assign w_hdr_dcnt = i_in_data[15:0];
  assign w_hdr_bad  = (w_hdr_icnt > MAX_CNT) | (w_hdr_dcnt > MAX_CNT);
  // Counts are non-zero whenever these are consulted, so icnt-1 cannot underflow.
  assign w_last_i   = (r_idx == r_icnt - CW'(1));
  assign w_last_d   = (r_idx == r_dcnt - CW'(1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    o_in_ready = 1'b0;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    o_err      = 1'b0;
    o_cpu_rst  = 1'b1;
    case (r_state)
      S_IDLE: begin
        o_in_ready = 1'b1;
        if (w_xfer) begin
          if (w_hdr_bad)              w_next = S_ERROR;
          else if (w_hdr_icnt != '0)  w_next = S_LOAD_I;
          else if (w_hdr_dcnt != '0)  w_next = S_LOAD_D;
          else                        w_next = S_RELEASE;
        end
      end
      S_LOAD_I: begin
        o_in_ready = 1'b1;
        o_busy     = 1'b1;
        if (w_xfer && w_last_i) begin
          w_next = (r_dcnt != '0) ? S_LOAD_D : S_RELEASE;
        end
      end
      S_LOAD_D: begin
        o_in_ready = 1'b1;
        o_busy     = 1'b1;
        if (w_xfer && w_last_d) begin
          w_next = S_RELEASE;
        end
      end
      S_RELEASE: begin
        o_busy = 1'b1;
        w_next = S_RUN;
      end
      S_RUN: begin
        o_done    = 1'b1;
        o_cpu_rst = 1'b0;
        if (i_reload) begin
          w_next = S_IDLE;
        end
      end
      S_ERROR: begin
        o_err = 1'b1;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Write path: the accepted word is registered so the strobe, address and
  // data all appear together in the cycle after the transfer edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx       <= '0;
      r_icnt      <= '0;
      r_dcnt      <= '0;
      r_inst_we   <= 1'b0;
      r_data_we   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_inst_we <= 1'b0;
      r_data_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_xfer && !w_hdr_bad) begin
            r_icnt <= w_hdr_icnt[CW-1:0];
            r_dcnt <= w_hdr_dcnt[CW-1:0];
            r_idx  <= '0;
          end
        end
        S_LOAD_I: begin
          if (w_xfer) begin
            r_inst_we   <= 1'b1;
            r_mem_addr  <= r_idx[ADDR_W-1:0];
            r_mem_wdata <= i_in_data;
            r_idx       <= w_last_i ? '0 : r_idx + CW'(1);
          end
        end
        S_LOAD_D: begin
          if (w_xfer) begin
            r_data_we   <= 1'b1;
            r_mem_addr  <= r_idx[ADDR_W-1:0];
            r_mem_wdata <= i_in_data;
            r_idx       <= w_last_d ? '0 : r_idx + CW'(1);
          end
        end
        S_RUN: begin
          if (i_reload) begin
            r_idx  <= '0;
            r_icnt <= '0;
            r_dcnt <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_inst_we   = r_inst_we;
  assign o_data_we   = r_data_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_boot_sequencer.sv
module tb_boot_sequencer;

  logic        clk;
  logic        i_rst;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [31:0] i_in_data;
  logic        i_reload;
  logic        o_inst_we;
  logic        o_data_we;
  logic [10:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        o_cpu_rst;
  logic        o_busy;
  logic        o_done;
  logic        o_err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit          is_inst;
    logic [10:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];

  boot_sequencer #(.ADDR_W(11), .DATA_W(32), .MEM_DEPTH(2048)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_data   (i_in_data),
    .i_reload    (i_reload),
    .o_inst_we   (o_inst_we),
    .o_data_we   (o_data_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_cpu_rst   (o_cpu_rst),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (o_inst_we && o_data_we) begin
      n_tests++;
      n_fail++;
      $display("FAIL dual_strobe: both strobes high at addr 0x%0h (t=%0t)", o_mem_addr, $time);
    end else if (o_inst_we || o_data_we) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: inst=%0b addr=0x%0h data=0x%0h expected none (t=%0t)",
                 o_inst_we, o_mem_addr, o_mem_wdata, $time);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_kind", 64'(o_inst_we), 64'(e.is_inst));
        chk("wr_addr", 64'(o_mem_addr), 64'(e.addr));
        chk("wr_data", 64'(o_mem_wdata), 64'(e.data));
      end
    end
  end

  task automatic check_reset_vals();
    chk("rst_inst_we", 64'(o_inst_we), 64'(0));
    chk("rst_data_we", 64'(o_data_we), 64'(0));
    chk("rst_addr",    64'(o_mem_addr), 64'(0));
    chk("rst_wdata",   64'(o_mem_wdata), 64'(0));
    chk("rst_cpu_rst", 64'(o_cpu_rst), 64'(1));
    chk("rst_busy",    64'(o_busy), 64'(0));
    chk("rst_done",    64'(o_done), 64'(0));
    chk("rst_err",     64'(o_err), 64'(0));
    chk("rst_ready",   64'(o_in_ready), 64'(1));
  endtask

  task automatic do_reset();
    i_in_valid = 1'b0;
    i_reload   = 1'b0;
    i_rst      = 1'b1;
    @(posedge clk); #1;
    check_reset_vals();
    i_rst = 1'b0;
  endtask

  // Presents one word; returns at posedge+1 after the transfer edge.
  task automatic send(input logic [31:0] d, output bit ok);
    bit rdy;
    ok = 1'b0;
    i_in_valid = 1'b1;
    i_in_data  = d;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      rdy = o_in_ready;
      @(posedge clk); #1;
      if (rdy) ok = 1'b1;
    end
    i_in_valid = 1'b0;
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: word 0x%0h not accepted expected accept within 20 cycles", d);
    end
  endtask

  task automatic idle_gap(input int gap_mode, input bit noise);
    int g;
    g = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
    for (int k = 0; k < g; k++) begin
      i_in_data = $urandom;
      i_reload  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
    end
    i_reload = 1'b0;
  endtask

  // Reference model: a load of icnt instruction words then dcnt data words
  // produces word k at imem[k] (k < icnt) or dmem[k-icnt]; a count above
  // 2048 produces no writes and the error state.
  task automatic do_load(input int ic, input int dc, input int gap_mode);
    bit   ok;
    bit   bad;
    int   total;
    wr_t  w;
    logic [31:0] d;
    bad   = (ic > 2048) || (dc > 2048);
    total = ic + dc;
    idle_gap(gap_mode, 1'b0);
    send({ic[15:0], dc[15:0]}, ok);
    if (!ok) return;
    if (bad) begin
      chk("err_flag",    64'(o_err), 64'(1));
      chk("err_ready",   64'(o_in_ready), 64'(0));
      chk("err_busy",    64'(o_busy), 64'(0));
      for (int k = 0; k < 20; k++) begin
        i_in_valid = 1'b1;
        i_in_data  = $urandom;
        @(posedge clk); #1;
        chk("err_hold", 64'({o_cpu_rst, o_err, o_in_ready, o_done}), 64'(4'b1100));
      end
      i_in_valid = 1'b0;
      do_reset();
      return;
    end
    if (total > 0) begin
      chk("hdr_busy", 64'({o_busy, o_in_ready, o_cpu_rst}), 64'(3'b111));
    end
    for (int k = 0; k < total; k++) begin
      d = $urandom;
      w.is_inst = (k < ic);
      w.addr    = (k < ic) ? 11'(k) : 11'(k - ic);
      w.data    = d;
      exp_q.push_back(w);
      send(d, ok);
      if (!ok) return;
      if (k != total - 1) idle_gap(gap_mode, 1'b1);
    end
    chk("release_state", 64'({o_busy, o_done, o_cpu_rst, o_in_ready}), 64'(4'b1010));
    @(posedge clk); #1;
    chk("run_state", 64'({o_busy, o_done, o_cpu_rst, o_in_ready, o_err}), 64'(5'b01000));
    chk("writes_left", 64'(exp_q.size()), 64'(0));
  endtask

  // In RUN: host words are ignored, then a reload pulse returns to IDLE.
  task automatic do_reload();
    i_in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_in_data = $urandom;
      @(posedge clk); #1;
    end
    i_in_valid = 1'b0;
    chk("run_ignores_valid", 64'({o_done, o_cpu_rst}), 64'(2'b10));
    i_reload = 1'b1;
    @(posedge clk); #1;
    i_reload = 1'b0;
    chk("reload_idle", 64'({o_cpu_rst, o_done, o_in_ready, o_busy}), 64'(4'b1010));
  endtask

  initial begin
    bit ok;
    wr_t w;
    int ic;
    int dc;
    i_rst      = 1'b1;
    i_in_valid = 1'b0;
    i_in_data  = '0;
    i_reload   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    do_load(3, 2, 0);
    do_reload();
    do_load(0, 0, 0);
    do_reload();
    do_load(2049, 1, 0);
    do_load(2, 1, 1);
    do_reload();
    do_load(1, 0, 0);
    do_reload();

    // Reset in the middle of a load.
    send(32'h0004_0000, ok);
    for (int k = 0; k < 2; k++) begin
      w.is_inst = 1'b1;
      w.addr    = 11'(k);
      w.data    = $urandom;
      exp_q.push_back(w);
      send(w.data, ok);
    end
    do_reset();
    do_load(4, 3, 2);
    do_reload();

    do_load(0, 3, 2);
    do_reload();
    do_load(1, 2049, 0);
    do_load(65535, 0, 0);

    for (int n = 0; n < 25; n++) begin
      ic = int'($urandom_range(0, 6));
      dc = int'($urandom_range(0, 6));
      do_load(ic, dc, int'($urandom_range(0, 2)));
      do_reload();
    end

    do_load(2048, 0, 0);
    do_reload();
    do_load(0, 2048, 0);
    do_reload();
    do_load(2048, 2048, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("final_queue_empty", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
